multadd_pipe: RTL and testbench
===============================

Name: multadd_pipe

Overview:
Parametrised multi-lane signed multiply-add/accumulate for the inverse-transform and interpolation datapaths. Each lane computes a*b+c, or accumulates a*b over a first..last run. Results pass through round/shift/saturate to P_BITS. Fixed 3-stage pipeline with a global clock enable for back-pressure; maps one DSP multiplier per lane.

Parameters:
A_BITS, 16, signed width of each a lane
B_BITS, 8, signed width of each b lane
C_BITS, 26, signed width of each c lane (must be <= ACC_BITS)
P_BITS, 26, signed width of each output lane
LANES, 4, number of parallel lanes
GUARD, 4, extra accumulator headroom bits; ACC_BITS = A_BITS+B_BITS+GUARD
SHIFT_BITS, 5, width of shift_i

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  pipeline enable; 0 freezes every register, including outputs
valid_i  in  1  input beat valid
first_i  in  1  first beat of an accumulate run (mode 1 only)
last_i  in  1  last beat of an accumulate run (mode 1 only)
mode_i  in  1  0 = per-beat a*b+c; 1 = accumulate
shift_i  in  SHIFT_BITS  right-shift amount, unsigned
a_i  in  LANES*A_BITS  lane k at [k*A_BITS +: A_BITS], signed
b_i  in  LANES*B_BITS  signed lanes, same packing
c_i  in  LANES*C_BITS  signed lanes, same packing
p_o  out  LANES*P_BITS  signed results, same packing
valid_o  out  1  p_o valid
ovf_o  out  LANES  per-lane saturation flag, qualified by valid_o

Behaviour:
- Reset (rst_n=0, asynchronous): p_o=0, valid_o=0, ovf_o=0, all pipeline valids=0, accumulators=0, no run open.
- All state advances only on a rising clk edge with en=1. With en=0 every register holds and outputs stay stable.
- S1: register a*b as a full-width signed product (A_BITS+B_BITS) per lane. Also register valid, first, last, mode, c and shift.
- S2, mode 0: sum = sext(prod)+sext(c). Result goes forward; the accumulator is untouched.
- S2, mode 1 with first: acc = sext(prod)+sext(c). With first=0: acc = acc+sext(prod); c is ignored.
- S2, mode 1: the result goes forward only on last. first and last on the same beat is a one-beat run, equivalent to mode 0.
- Accumulator arithmetic wraps at ACC_BITS. Headroom is the caller's responsibility.
- S3, shift s: effective s = min(shift_i, ACC_BITS-1). If s>0, r = (x + 2^(s-1)) >>> s (arithmetic, round half up). If s=0, r = x.
- S3, saturation: r is saturated to [-2^(P_BITS-1), 2^(P_BITS-1)-1]. ovf_o[k]=1 when lane k clipped.
- S3 output register drives p_o and valid_o.
- Latency: exactly 3 enabled cycles from an accepted beat (valid_i=1, en=1) to valid_o. In mode 1, the latency is measured from the last beat.
- Throughput: one beat per enabled cycle. Bubbles (valid_i=0) leave the accumulator unchanged and propagate as valid_o=0.
- valid_o=0 cycles: p_o and ovf_o hold their last values.
- Mode 1, first while a run is open: the partial sum is discarded and a new run starts.
- Mode 1, beat without first and no run open: accumulates onto the current acc value (0 after reset).
- Mode 0 beat inside an open run: produces its own result; acc and the open run are preserved.
- shift_i is sampled per beat. In mode 1 the value on the last beat is used.
- rst_n asserted mid-run: the partial accumulation and in-flight results are lost. No output appears for beats accepted before reset.

Test Plan:
- Mode 0, one lane, a=300, b=-5, c=1000, shift=0: exactly 3 cycles later valid_o=1, p=-500, ovf=0. Other lanes fed distinct values return independent results.
- Mode 1, 4-beat run, a=100,200,300,400, b=2, c=7 on first, shift=2: single valid_o after last, p=(2007+2)>>>2=502. No valid_o on the 3 earlier beats.
- Rounding on negatives: mode 0, a*b+c=-3 with shift=1 gives -1; -5 with shift=1 gives -2; shift=31 is clamped to ACC_BITS-1.
- Saturation: a=32767, b=127, c=2^25-1, P_BITS=26: p=2^25-1, ovf=1. Matching negative case gives p=-2^25, ovf=1.
- Stall: toggle en low for 5 cycles mid-stream of 10 mode-0 beats. All 10 results arrive in order with none lost or duplicated, and outputs are frozen while en=0.
- Reset mid-run: assert rst_n=0 after 2 beats of a mode-1 run. All outputs go to 0 asynchronously. The next first..last run gives the correct sum with no residue.

Source files
------------

// File: rtl/multadd_pipe.sv
// Multi-lane signed multiply-add / accumulate with round, shift and saturate.
// Three registered stages (product, add/accumulate, round+saturate) behind one global enable.
module multadd_pipe #(
    parameter int A_BITS     = 16,
    parameter int B_BITS     = 8,
    parameter int C_BITS     = 26,
    parameter int P_BITS     = 26,
    parameter int LANES      = 4,
    parameter int GUARD      = 4,
    parameter int SHIFT_BITS = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       valid_i,
    input  logic                       first_i,
    input  logic                       last_i,
    input  logic                       mode_i,
    input  logic [SHIFT_BITS-1:0]      shift_i,
    input  logic [LANES*A_BITS-1:0]    a_i,
    input  logic [LANES*B_BITS-1:0]    b_i,
    input  logic [LANES*C_BITS-1:0]    c_i,
    output logic [LANES*P_BITS-1:0]    p_o,
    output logic                       valid_o,
    output logic [LANES-1:0]           ovf_o
);
    localparam int PROD_BITS = A_BITS + B_BITS;
    localparam int ACC_BITS  = PROD_BITS + GUARD;
    localparam int RW        = ACC_BITS + 1;
    localparam int unsigned MAX_SH = ACC_BITS - 1;
    localparam logic signed [RW-1:0] PMAX = RW'((64'sd1 <<< (P_BITS - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] PMIN = ~PMAX;

    // Stage 1
    logic signed [PROD_BITS-1:0] prod_d [LANES];
    logic signed [PROD_BITS-1:0] prod_q [LANES];
    logic signed [C_BITS-1:0]    c1_q   [LANES];
    logic                        v1_q, first1_q, last1_q, mode1_q;
    logic [SHIFT_BITS-1:0]       sh1_q;

    // Stage 2
    logic signed [ACC_BITS-1:0]  sum_w  [LANES];
    logic signed [ACC_BITS-1:0]  accp_w [LANES];
    logic signed [ACC_BITS-1:0]  acc_d  [LANES];
    logic signed [ACC_BITS-1:0]  acc_q  [LANES];
    logic signed [ACC_BITS-1:0]  res_d  [LANES];
    logic signed [ACC_BITS-1:0]  res_q  [LANES];
    logic                        v2_d, v2_q;
    logic [SHIFT_BITS-1:0]       sh2_q;

    // Stage 3
    logic signed [RW-1:0]        xr_w   [LANES];
    logic signed [RW-1:0]        rr_w   [LANES];
    logic signed [RW-1:0]        rnd_w;
    int unsigned                 sh_eff;
    logic [LANES*P_BITS-1:0]     p_d, p_q;
    logic [LANES-1:0]            ovf_d, ovf_q;
    logic                        valid_q;

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            prod_d[k] = PROD_BITS'($signed(a_i[k*A_BITS +: A_BITS]))
                      * PROD_BITS'($signed(b_i[k*B_BITS +: B_BITS]));
        end
    end

    // A result leaves stage 2 for every mode-0 beat and for the closing beat of a run.
    always_comb begin
        v2_d = v1_q && (!mode1_q || last1_q);
        for (int unsigned k = 0; k < LANES; k++) begin
            sum_w[k]  = ACC_BITS'(prod_q[k]) + ACC_BITS'(c1_q[k]);
            accp_w[k] = acc_q[k] + ACC_BITS'(prod_q[k]);
            acc_d[k]  = acc_q[k];
            res_d[k]  = sum_w[k];
            if (v1_q && mode1_q) begin
                acc_d[k] = first1_q ? sum_w[k] : accp_w[k];
                res_d[k] = acc_d[k];
            end
        end
    end

    always_comb begin
        sh_eff = 32'(sh2_q);
        if (sh_eff > MAX_SH) sh_eff = MAX_SH;
        rnd_w = '0;
        if (sh_eff != 0) rnd_w = RW'(1) <<< (sh_eff - 1);
        p_d   = p_q;
        ovf_d = ovf_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            xr_w[k] = RW'(res_q[k]);
            rr_w[k] = (xr_w[k] + rnd_w) >>> sh_eff;
            if (v2_q) begin
                if (rr_w[k] > PMAX) begin
                    p_d[k*P_BITS +: P_BITS] = PMAX[P_BITS-1:0];
                    ovf_d[k] = 1'b1;
                end else if (rr_w[k] < PMIN) begin
                    p_d[k*P_BITS +: P_BITS] = PMIN[P_BITS-1:0];
                    ovf_d[k] = 1'b1;
                end else begin
                    p_d[k*P_BITS +: P_BITS] = rr_w[k][P_BITS-1:0];
                    ovf_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
                c1_q[k]   <= '0;
                acc_q[k]  <= '0;
                res_q[k]  <= '0;
            end
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            mode1_q  <= 1'b0;
            sh1_q    <= '0;
            v2_q     <= 1'b0;
            sh2_q    <= '0;
            p_q      <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                prod_q[k] <= prod_d[k];
                c1_q[k]   <= $signed(c_i[k*C_BITS +: C_BITS]);
                acc_q[k]  <= acc_d[k];
                res_q[k]  <= res_d[k];
            end
            v1_q     <= valid_i;
            first1_q <= first_i;
            last1_q  <= last_i;
            mode1_q  <= mode_i;
            sh1_q    <= shift_i;
            v2_q     <= v2_d;
            sh2_q    <= sh1_q;
            p_q      <= p_d;
            ovf_q    <= ovf_d;
            valid_q  <= v2_q;
        end
    end

    assign p_o     = p_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_multadd_pipe.sv
// Self-checking bench for multadd_pipe: vector table plus hand sequences,
// with a timestamped scoreboard checking every enabled output cycle.
module tb_multadd_pipe;
    localparam int LN = 4;
    localparam int PB = 26;

    logic               clk = 1'b0;
    logic               rst_n, en, valid_i, first_i, last_i, mode_i;
    logic [4:0]         shift_i;
    logic [LN*16-1:0]   a_i;
    logic [LN*8-1:0]    b_i;
    logic [LN*26-1:0]   c_i;
    logic [LN*PB-1:0]   p_o;
    logic               valid_o;
    logic [LN-1:0]      ovf_o;

    multadd_pipe #(
        .A_BITS(16), .B_BITS(8), .C_BITS(26), .P_BITS(PB),
        .LANES(LN), .GUARD(4), .SHIFT_BITS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(valid_i),
        .first_i(first_i), .last_i(last_i), .mode_i(mode_i),
        .shift_i(shift_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .p_o(p_o), .valid_o(valid_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef logic [3:0][31:0] l4_t;
    typedef struct {
        bit          mode, first, last;
        int unsigned sh;
        l4_t         a, b, c, p;
        logic [3:0]  ovf;
    } vec_t;
    typedef struct {
        logic [LN*PB-1:0] p;
        logic [LN-1:0]    ovf;
        int unsigned      due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned ecyc = 0;
    bit          adv = 0;
    logic [LN*PB-1:0] snap_p = '0;
    logic             snap_v = 1'b0;
    logic [LN-1:0]    snap_ovf = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic l4_t l4(input int x0, input int x1, input int x2, input int x3);
        l4_t r;
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
        return r;
    endfunction

    function automatic void model(input longint x, input int unsigned sh,
                                  output logic [31:0] p, output logic ovf);
        int unsigned s;
        longint r;
        s = (sh > 27) ? 27 : sh;
        r = (s == 0) ? x : ((x + (longint'(1) <<< (s - 1))) >>> s);
        ovf = 1'b0;
        if (r > 33554431) begin r = 33554431; ovf = 1'b1; end
        else if (r < -33554432) begin r = -33554432; ovf = 1'b1; end
        p = r[31:0];
    endfunction

    always @(posedge clk) begin
        adv = en;
        if (en) ecyc++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (adv) begin
                exp_t e;
                bit   exp_v;
                exp_v = (q.size() > 0) && (q[0].due == ecyc);
                chk("valid_o", longint'(valid_o), longint'(exp_v));
                if (exp_v) begin
                    e = q.pop_front();
                    for (int k = 0; k < LN; k++) begin
                        chk($sformatf("p_o lane%0d", k),
                            longint'($signed(p_o[k*PB +: PB])), longint'($signed(e.p[k*PB +: PB])));
                        chk($sformatf("ovf_o lane%0d", k), longint'(ovf_o[k]), longint'(e.ovf[k]));
                    end
                end
                snap_p = p_o; snap_v = valid_o; snap_ovf = ovf_o;
            end else begin
                chk("stall hold p_o", longint'(p_o == snap_p), 1);
                chk("stall hold valid_o", longint'(valid_o), longint'(snap_v));
                chk("stall hold ovf_o", longint'(ovf_o), longint'(snap_ovf));
            end
        end
    end

    task automatic beat(input bit v, input bit mode, input bit first, input bit last,
                        input int unsigned sh, input l4_t a, input l4_t b, input l4_t c);
        @(negedge clk);
        en = 1'b1; valid_i = v; mode_i = mode; first_i = first; last_i = last;
        shift_i = sh[4:0];
        for (int k = 0; k < LN; k++) begin
            a_i[k*16 +: 16] = a[k][15:0];
            b_i[k*8 +: 8]   = b[k][7:0];
            c_i[k*26 +: 26] = c[k][25:0];
        end
    endtask

    task automatic push(input l4_t p, input logic [3:0] ovf);
        exp_t e;
        e.due = ecyc + 3;
        e.ovf = ovf;
        for (int k = 0; k < LN; k++) e.p[k*PB +: PB] = p[k][PB-1:0];
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, l4(0,0,0,0), l4(0,0,0,0), l4(0,0,0,0));
    endtask

    vec_t tbl[6];

    initial begin
        l4_t z, one, pm;
        logic [3:0] om;
        logic [31:0] pv;
        logic ov;
        z   = l4(0, 0, 0, 0);
        one = l4(1, 1, 1, 1);

        tbl[0] = '{0, 0, 0, 0,  l4(300, -7, 1000, -32768), l4(-5, 9, 100, -128),
                   l4(1000, 0, -5, 0), l4(-500, -63, 99995, 4194304), 4'b0000};
        tbl[1] = '{0, 0, 0, 1,  z, z, l4(-3, -5, 3, 5), l4(-1, -2, 2, 3), 4'b0000};
        tbl[2] = '{0, 0, 0, 31, l4(0, -32768, 0, 0), l4(0, 127, 0, 0),
                   l4(33554431, -33554432, -1, 0), l4(0, 0, 0, 0), 4'b0000};
        tbl[3] = '{0, 1, 1, 0,  l4(32767, -32768, 1, -1), l4(127, 127, 1, 1),
                   l4(33554431, -33554432, 33554430, -33554431),
                   l4(33554431, -33554432, 33554431, -33554432), 4'b0011};
        tbl[4] = '{0, 0, 0, 24, l4(0, 0, 32767, 0), l4(0, 0, 127, 0),
                   l4(33554431, -33554432, 33554431, -8388608), l4(2, -2, 2, 0), 4'b0000};
        tbl[5] = '{0, 0, 0, 4,  l4(-3, 0, 0, 0), l4(5, 0, 0, 0), l4(8, 0, 0, 0), z, 4'b0000};

        rst_n = 1'b0; en = 1'b1; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        mode_i = 1'b0; shift_i = '0; a_i = '0; b_i = '0; c_i = '0;
        repeat (3) @(negedge clk);
        chk("reset p_o", longint'(p_o == '0), 1);
        chk("reset valid_o", longint'(valid_o), 0);
        chk("reset ovf_o", longint'(ovf_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            beat(1, tbl[i].mode, tbl[i].first, tbl[i].last, tbl[i].sh, tbl[i].a, tbl[i].b, tbl[i].c);
            push(tbl[i].p, tbl[i].ovf);
        end
        idle(5);

        // Four-beat accumulate run; c and shift only matter on first / last.
        beat(1, 1, 1, 0, 9, l4(100,100,100,100), l4(2,3,-1,0), l4(7,7,7,7));
        beat(1, 1, 0, 0, 9, l4(200,200,200,200), l4(2,3,-1,0), l4(99,99,99,99));
        beat(1, 1, 0, 0, 9, l4(300,300,300,300), l4(2,3,-1,0), l4(99,99,99,99));
        beat(1, 1, 0, 1, 2, l4(400,400,400,400), l4(2,3,-1,0), l4(99,99,99,99));
        push(l4(502, 752, -248, 2), 4'b0000);
        idle(5);

        // Open run interrupted by a mode-0 beat, then restarted by a new first.
        beat(1, 1, 1, 0, 0, l4(50,50,50,50), one, l4(10,10,10,10));
        beat(1, 0, 0, 0, 0, l4(5,5,5,5), one, one);
        push(l4(6,6,6,6), 4'b0000);
        beat(1, 1, 1, 0, 0, l4(20,20,20,20), one, l4(3,3,3,3));
        beat(1, 1, 0, 1, 0, l4(30,30,30,30), one, z);
        push(l4(53,53,53,53), 4'b0000);
        idle(5);

        // Ten mode-0 beats with a five-cycle stall after the fourth.
        for (int i = 0; i < 10; i++) begin
            l4_t a, b, c;
            int unsigned sh;
            if (i == 4) begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    en = 1'b0; valid_i = 1'b1; mode_i = 1'b0;
                    a_i = {$urandom, $urandom}; c_i = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            sh = $urandom_range(8);
            for (int k = 0; k < LN; k++) begin
                a[k] = int'($urandom_range(4000)) - 2000;
                b[k] = int'($urandom_range(200)) - 100;
                c[k] = int'($urandom_range(200000)) - 100000;
                model(longint'($signed(a[k])) * longint'($signed(b[k])) + longint'($signed(c[k])),
                      sh, pv, ov);
                pm[k] = pv; om[k] = ov;
            end
            beat(1, 0, 0, 0, sh, a, b, c);
            push(pm, om);
        end
        idle(5);

        // Reset after two beats of a run: outputs clear at once, no residue afterwards.
        beat(1, 1, 1, 0, 0, l4(11,12,13,14), one, l4(1,1,1,1));
        beat(1, 1, 0, 0, 0, l4(21,22,23,24), one, z);
        @(negedge clk);
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset p_o", longint'(p_o == '0), 1);
        chk("async reset valid_o", longint'(valid_o), 0);
        chk("async reset ovf_o", longint'(ovf_o), 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat(1, 1, 0, 1, 0, l4(4,5,6,7), one, l4(99,99,99,99));
        push(l4(4,5,6,7), 4'b0000);
        beat(1, 1, 1, 0, 0, l4(1,1,1,1), one, z);
        beat(1, 1, 0, 1, 0, l4(2,2,2,2), one, z);
        push(l4(3,3,3,3), 4'b0000);

        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        idle(2);
        chk("scoreboard drained", longint'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
